// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC result-return path.
//   CORDIC_XLEN          : default result width
//   CORDIC_TRANS_ID_BITS : default scoreboard transaction-ID width
//   CORDIC_DEPTH         : default buffer depth / credit limit
//   cordic_wb_t          : writeback record {result, trans_id}; the FIFO
//                          payload uses the same packing order
//   cnt_width()          : width of a counter that must hold 0..depth
// -----------------------------------------------------------------------------
package cordic_pkg;

  localparam int CORDIC_XLEN          = 32;
  localparam int CORDIC_TRANS_ID_BITS = 3;
  localparam int CORDIC_DEPTH         = 4;

  typedef struct packed {
    logic [CORDIC_XLEN-1:0]          result;
    logic [CORDIC_TRANS_ID_BITS-1:0] trans_id;
  } cordic_wb_t;

  // A counter spanning 0..depth inclusive needs one bit more than a pointer.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cordic_wb_fifo.sv
// -----------------------------------------------------------------------------
// cordic_wb_fifo
// DEPTH-entry first-word-fallthrough FIFO with synchronous flush.
//   clk_i    in  : clock
//   rst_i    in  : asynchronous active-high reset
//   flush_i  in  : empties the FIFO; push and pop are ignored that cycle
//   push_i   in  : write data_i (ignored when full)
//   data_i   in  : write data
//   pop_i    in  : advance the read pointer (ignored when empty)
//   data_o   out : head entry, zero while empty
//   full_o   out : occupancy == DEPTH
//   empty_o  out : occupancy == 0
//   occ_o    out : current occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module cordic_wb_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] occ_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (occ_q == CW'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign occ_o   = occ_q;

  assign do_push = push_i & !full_o  & !flush_i;
  assign do_pop  = pop_i  & !empty_o & !flush_i;

  // Pointers are exactly log2(DEPTH) bits, so natural overflow is the
  // modulo-DEPTH wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      occ_d = occ_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Head is read straight from storage (fall-through). Gating with empty
  // keeps the output at zero out of reset and after a flush.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/cordic_wb_buffer.sv
// -----------------------------------------------------------------------------
// cordic_wb_buffer
// Buffers one-cycle CORDIC result pulses (no backpressure) and returns them to
// the scoreboard over a valid/ready writeback port. Issue into the unit is
// credit-limited to DEPTH outstanding operations so every result has a slot.
// Results of operations killed by a flush are counted and discarded.
//   clk_i, rst_i               : clock, asynchronous active-high reset
//   flush_i                    : kill all pending and buffered operations
//   issue_valid_i/issue_ready_o: dispatcher handshake
//   cordic_ready_i             : unit can take an operation
//   cordic_req_o               : issue strobe to the unit
//   cordic_valid_i/_result_i/_trans_id_i : result pulse from the unit
//   wb_valid_o/wb_ready_i      : writeback handshake
//   wb_result_o/wb_trans_id_o  : head entry
//   overflow_o                 : sticky protocol-error flag
// -----------------------------------------------------------------------------
module cordic_wb_buffer
  import cordic_pkg::*;
#(
  parameter int DEPTH         = CORDIC_DEPTH,
  parameter int XLEN          = CORDIC_XLEN,
  parameter int TRANS_ID_BITS = CORDIC_TRANS_ID_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic                     cordic_ready_i,
  output logic                     cordic_req_o,
  input  logic                     cordic_valid_i,
  input  logic [XLEN-1:0]          cordic_result_i,
  input  logic [TRANS_ID_BITS-1:0] cordic_trans_id_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [XLEN-1:0]          wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic                     overflow_o
);

  localparam int CW = cnt_width(DEPTH);
  localparam int EW = XLEN + TRANS_ID_BITS;

  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          overflow_q, overflow_d;

  logic [CW-1:0] fifo_occ;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] fifo_rdata;

  logic [CW-1:0] pend;
  logic [CW-1:0] flush_keep;
  logic          issue;
  logic          pop;
  logic          orphan;
  logic          claimed;
  logic          discard;
  logic          push;
  logic          push_full;

  // ---------------------------------------------------------------------------
  // Issue side: credit check against the registered outstanding count.
  // ---------------------------------------------------------------------------
  assign issue_ready_o = !rst_i & !flush_i & cordic_ready_i & (out_cnt_q < CW'(DEPTH));
  assign issue         = issue_valid_i & issue_ready_o;
  assign cordic_req_o  = issue;

  // ---------------------------------------------------------------------------
  // Result classification.
  // pend counts results still owed by the unit; a result with nothing owed is
  // a protocol error. A result that is owed is either a killed one (drop_cnt
  // non-zero) or a live one to buffer. drop_cnt never exceeds pend, so the
  // orphan test alone decides the error case.
  // ---------------------------------------------------------------------------
  assign pend      = out_cnt_q - fifo_occ;
  assign orphan    = cordic_valid_i & (pend == '0);
  assign claimed   = cordic_valid_i & !orphan;
  assign discard   = claimed & !flush_i & (drop_cnt_q != '0);
  assign push_full = claimed & !flush_i & (drop_cnt_q == '0) & fifo_full;
  assign push      = claimed & !flush_i & (drop_cnt_q == '0) & !fifo_full;

  // ---------------------------------------------------------------------------
  // Writeback side. A flush hides the head so nothing retires that cycle.
  // ---------------------------------------------------------------------------
  assign wb_valid_o = !fifo_empty & !flush_i;
  assign pop        = wb_valid_o & wb_ready_i;

  // After a flush every operation still owed by the unit becomes a kill; a
  // result landing in the flush cycle itself is already accounted for.
  assign flush_keep = claimed ? (pend - CW'(1)) : pend;

  always_comb begin
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q | orphan | push_full;
    if (flush_i) begin
      out_cnt_d  = flush_keep;
      drop_cnt_d = flush_keep;
    end else begin
      out_cnt_d = out_cnt_q + CW'(issue) - CW'(pop) - CW'(discard);
      if (discard) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow_o = overflow_q;

  // ---------------------------------------------------------------------------
  // Result buffer. Payload packing matches cordic_wb_t: {result, trans_id}.
  // ---------------------------------------------------------------------------
  cordic_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  ({cordic_result_i, cordic_trans_id_i}),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .occ_o   (fifo_occ)
  );

  assign wb_result_o   = fifo_rdata[EW-1:TRANS_ID_BITS];
  assign wb_trans_id_o = fifo_rdata[TRANS_ID_BITS-1:0];

endmodule

// File: tb/tb_cordic_wb_buffer.sv
module tb_cordic_wb_buffer;
  import cordic_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int TIDB  = 3;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic            cordic_ready_i;
  logic            cordic_req_o;
  logic            cordic_valid_i;
  logic [XLEN-1:0] cordic_result_i;
  logic [TIDB-1:0] cordic_trans_id_i;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic [XLEN-1:0] wb_result_o;
  logic [TIDB-1:0] wb_trans_id_o;
  logic            overflow_o;

  int tests = 0;
  int fails = 0;
  cordic_wb_t exp_q[$];
  cordic_wb_t head;
  cordic_wb_t ent;

  always #5 clk_i = ~clk_i;

  cordic_wb_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .TRANS_ID_BITS(TIDB)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .flush_i           (flush_i),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .cordic_ready_i    (cordic_ready_i),
    .cordic_req_o      (cordic_req_o),
    .cordic_valid_i    (cordic_valid_i),
    .cordic_result_i   (cordic_result_i),
    .cordic_trans_id_i (cordic_trans_id_i),
    .wb_valid_o        (wb_valid_o),
    .wb_ready_i        (wb_ready_i),
    .wb_result_o       (wb_result_o),
    .wb_trans_id_o     (wb_trans_id_o),
    .overflow_o        (overflow_o)
  );

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    flush_i = 1'b0; issue_valid_i = 1'b0; cordic_ready_i = 1'b1;
    cordic_valid_i = 1'b0; cordic_result_i = '0; cordic_trans_id_i = '0; wb_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    issue_valid_i = 1'b1;
    rst_i = 1'b1;
    step(); step();
    settle();
    tests++; if (issue_ready_o !== 1'b0) begin fails++; $display("FAIL reset_issue_ready: got %b want 0", issue_ready_o); end
    tests++; if (cordic_req_o !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", cordic_req_o); end
    tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid_o); end
    tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
    tests++; if (wb_result_o !== 32'h0 || wb_trans_id_o !== 3'd0) begin fails++; $display("FAIL reset_wb_data: got %h/%0d want 0/0", wb_result_o, wb_trans_id_o); end
    tests++; if (dut.out_cnt_q !== 3'd0 || dut.drop_cnt_q !== 3'd0) begin fails++; $display("FAIL reset_counters: got out=%0d drop=%0d want 0/0", dut.out_cnt_q, dut.drop_cnt_q); end
    rst_i = 1'b0;
    issue_valid_i = 1'b0;
    step();
    $display("[TB] reset released");
  endtask

  task automatic test_single();
    issue_valid_i = 1'b1;
    settle();
    tests++; if (issue_ready_o !== 1'b1 || cordic_req_o !== 1'b1) begin fails++; $display("FAIL single_issue: got ready=%b req=%b want 1/1", issue_ready_o, cordic_req_o); end
    step();
    issue_valid_i = 1'b0;
    settle();
    tests++; if (dut.out_cnt_q !== 3'd1) begin fails++; $display("FAIL single_out_cnt_issue: got %0d want 1", dut.out_cnt_q); end
    repeat (4) step();
    cordic_valid_i = 1'b1; cordic_result_i = 32'h3F60_A8B2; cordic_trans_id_i = 3'd1;
    settle();
    tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL single_no_bypass: got %b want 0", wb_valid_o); end
    step();
    cordic_valid_i = 1'b0;
    settle();
    tests++; if (wb_valid_o !== 1'b1) begin fails++; $display("FAIL single_wb_valid: got %b want 1", wb_valid_o); end
    tests++; if (wb_result_o !== 32'h3F60_A8B2 || wb_trans_id_o !== 3'd1) begin fails++; $display("FAIL single_wb_data: got %h/%0d want 3f60a8b2/1", wb_result_o, wb_trans_id_o); end
    wb_ready_i = 1'b1;
    step();
    wb_ready_i = 1'b0;
    settle();
    tests++; if (dut.out_cnt_q !== 3'd0 || wb_valid_o !== 1'b0) begin fails++; $display("FAIL single_retire: got out=%0d valid=%b want 0/0", dut.out_cnt_q, wb_valid_o); end
    $display("[TB] single: result 3f60a8b2 tid 1 written back");
  endtask

  task automatic test_credit();
    issue_valid_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    settle();
    tests++; if (issue_ready_o !== 1'b0 || cordic_req_o !== 1'b0) begin fails++; $display("FAIL credit_block: got ready=%b req=%b want 0/0", issue_ready_o, cordic_req_o); end
    tests++; if (dut.out_cnt_q !== 3'd4) begin fails++; $display("FAIL credit_out_cnt: got %0d want 4", dut.out_cnt_q); end
    issue_valid_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cordic_valid_i = 1'b1; cordic_result_i = 32'h100 + 32'(i); cordic_trans_id_i = 3'(i);
      step();
    end
    cordic_valid_i = 1'b0;
    settle();
    tests++; if (dut.fifo_occ !== 3'd4) begin fails++; $display("FAIL credit_full: got occ=%0d want 4", dut.fifo_occ); end
    tests++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'h100 || wb_trans_id_o !== 3'd0) begin fails++; $display("FAIL credit_head: got %b %h/%0d want 1 100/0", wb_valid_o, wb_result_o, wb_trans_id_o); end
    step();
    settle();
    tests++; if (wb_result_o !== 32'h100 || issue_ready_o !== 1'b0) begin fails++; $display("FAIL credit_stable: got %h ready=%b want 100 ready=0", wb_result_o, issue_ready_o); end
    wb_ready_i = 1'b1;
    step();
    wb_ready_i = 1'b0;
    settle();
    tests++; if (issue_ready_o !== 1'b1 || dut.out_cnt_q !== 3'd3) begin fails++; $display("FAIL credit_release: got ready=%b out=%0d want 1/3", issue_ready_o, dut.out_cnt_q); end
    $display("[TB] credit: popped 00000100 tid 0");
    // Back-to-back drain at one per cycle.
    wb_ready_i = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      settle();
      tests++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'h100 + 32'(i) || wb_trans_id_o !== 3'(i)) begin fails++; $display("FAIL credit_drain_%0d: got %b %h/%0d want 1 %h/%0d", i, wb_valid_o, wb_result_o, wb_trans_id_o, 32'h100 + 32'(i), i); end
      $display("[TB] credit: popped %h tid %0d", wb_result_o, wb_trans_id_o);
      step();
    end
    wb_ready_i = 1'b0;
    settle();
    tests++; if (wb_valid_o !== 1'b0 || dut.out_cnt_q !== 3'd0) begin fails++; $display("FAIL credit_empty: got valid=%b out=%0d want 0/0", wb_valid_o, dut.out_cnt_q); end
  endtask

  task automatic test_flush_outstanding();
    issue_valid_i = 1'b1;
    repeat (3) step();
    issue_valid_i = 1'b0;
    cordic_valid_i = 1'b1; cordic_result_i = 32'hAAAA_0001; cordic_trans_id_i = 3'd5;
    step();
    cordic_valid_i = 1'b0;
    flush_i = 1'b1; issue_valid_i = 1'b1;
    settle();
    tests++; if (wb_valid_o !== 1'b0 || issue_ready_o !== 1'b0 || cordic_req_o !== 1'b0) begin fails++; $display("FAIL flush_gating: got valid=%b ready=%b req=%b want 0/0/0", wb_valid_o, issue_ready_o, cordic_req_o); end
    step();
    flush_i = 1'b0; issue_valid_i = 1'b0;
    settle();
    tests++; if (dut.fifo_occ !== 3'd0 || dut.drop_cnt_q !== 3'd2 || dut.out_cnt_q !== 3'd2) begin fails++; $display("FAIL flush_counts: got occ=%0d drop=%0d out=%0d want 0/2/2", dut.fifo_occ, dut.drop_cnt_q, dut.out_cnt_q); end
    for (int i = 0; i < 2; i++) begin
      cordic_valid_i = 1'b1; cordic_result_i = 32'hDEAD_0000 + 32'(i); cordic_trans_id_i = 3'(i + 2);
      step();
      cordic_valid_i = 1'b0;
      settle();
      tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL flush_killed_%0d: got valid=%b want 0", i, wb_valid_o); end
      $display("[TB] flush: killed result %h discarded", 32'hDEAD_0000 + 32'(i));
    end
    tests++; if (dut.drop_cnt_q !== 3'd0 || dut.out_cnt_q !== 3'd0 || overflow_o !== 1'b0) begin fails++; $display("FAIL flush_drained: got drop=%0d out=%0d ovf=%b want 0/0/0", dut.drop_cnt_q, dut.out_cnt_q, overflow_o); end
    issue_valid_i = 1'b1;
    step();
    issue_valid_i = 1'b0;
    cordic_valid_i = 1'b1; cordic_result_i = 32'hBEEF_0006; cordic_trans_id_i = 3'd6;
    step();
    cordic_valid_i = 1'b0;
    settle();
    tests++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'hBEEF_0006 || wb_trans_id_o !== 3'd6) begin fails++; $display("FAIL flush_fresh: got %b %h/%0d want 1 beef0006/6", wb_valid_o, wb_result_o, wb_trans_id_o); end
    wb_ready_i = 1'b1;
    step();
    wb_ready_i = 1'b0;
    settle();
    tests++; if (dut.out_cnt_q !== 3'd0) begin fails++; $display("FAIL flush_fresh_retire: got out=%0d want 0", dut.out_cnt_q); end
    $display("[TB] flush: fresh result beef0006 tid 6 written back");
  endtask

  task automatic test_flush_coincident();
    issue_valid_i = 1'b1;
    repeat (2) step();
    issue_valid_i = 1'b0;
    flush_i = 1'b1;
    cordic_valid_i = 1'b1; cordic_result_i = 32'h1111_1111; cordic_trans_id_i = 3'd3;
    step();
    cordic_valid_i = 1'b0;
    flush_i = 1'b0;
    settle();
    tests++; if (dut.drop_cnt_q !== 3'd1 || dut.out_cnt_q !== 3'd1 || wb_valid_o !== 1'b0) begin fails++; $display("FAIL coinc_counts: got drop=%0d out=%0d valid=%b want 1/1/0", dut.drop_cnt_q, dut.out_cnt_q, wb_valid_o); end
    // Two flushes in a row recompute from the unchanged pend.
    flush_i = 1'b1;
    repeat (2) step();
    flush_i = 1'b0;
    settle();
    tests++; if (dut.drop_cnt_q !== 3'd1 || dut.out_cnt_q !== 3'd1) begin fails++; $display("FAIL coinc_b2b_flush: got drop=%0d out=%0d want 1/1", dut.drop_cnt_q, dut.out_cnt_q); end
    cordic_valid_i = 1'b1; cordic_result_i = 32'h2222_2222; cordic_trans_id_i = 3'd4;
    step();
    cordic_valid_i = 1'b0;
    settle();
    tests++; if (dut.drop_cnt_q !== 3'd0 || dut.out_cnt_q !== 3'd0 || wb_valid_o !== 1'b0 || overflow_o !== 1'b0) begin fails++; $display("FAIL coinc_drained: got drop=%0d out=%0d valid=%b ovf=%b want 0/0/0/0", dut.drop_cnt_q, dut.out_cnt_q, wb_valid_o, overflow_o); end
    $display("[TB] coincident: result 11111111 dropped by flush, 22222222 discarded");
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    issue_valid_i = 1'b1;
    repeat (3) step();
    issue_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ent.result = 32'h4000_0000 + 32'(i); ent.trans_id = 3'(i);
      cordic_valid_i = 1'b1; cordic_result_i = ent.result; cordic_trans_id_i = ent.trans_id;
      exp_q.push_back(ent);
      step();
    end
    cordic_valid_i = 1'b0;
    // Issue, push and pop every cycle; nine results pass through a 4-deep ring.
    for (int i = 0; i < 9; i++) begin
      ent.result = 32'h5000_0000 + 32'(i); ent.trans_id = 3'(i);
      issue_valid_i = (i < 8);
      cordic_valid_i = 1'b1; cordic_result_i = ent.result; cordic_trans_id_i = ent.trans_id;
      wb_ready_i = 1'b1;
      settle();
      head = exp_q[0];
      tests++; if (wb_valid_o !== 1'b1 || wb_result_o !== head.result || wb_trans_id_o !== head.trans_id) begin fails++; $display("FAIL simul_head_%0d: got %b %h/%0d want 1 %h/%0d", i, wb_valid_o, wb_result_o, wb_trans_id_o, head.result, head.trans_id); end
      $display("[TB] simul: popped %h tid %0d, pushed %h", wb_result_o, wb_trans_id_o, ent.result);
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(ent);
      tests++; if (dut.fifo_occ !== 3'd2 || dut.out_cnt_q !== ((i < 8) ? 3'd3 : 3'd2)) begin fails++; $display("FAIL simul_occ_%0d: got occ=%0d out=%0d want 2/%0d", i, dut.fifo_occ, dut.out_cnt_q, (i < 8) ? 3 : 2); end
    end
    issue_valid_i = 1'b0;
    cordic_valid_i = 1'b0;
    while (exp_q.size() > 0) begin
      settle();
      head = exp_q[0];
      tests++; if (wb_valid_o !== 1'b1 || wb_result_o !== head.result || wb_trans_id_o !== head.trans_id) begin fails++; $display("FAIL simul_drain: got %b %h/%0d want 1 %h/%0d", wb_valid_o, wb_result_o, wb_trans_id_o, head.result, head.trans_id); end
      $display("[TB] simul: popped %h tid %0d", wb_result_o, wb_trans_id_o);
      step();
      void'(exp_q.pop_front());
    end
    wb_ready_i = 1'b0;
    settle();
    tests++; if (wb_valid_o !== 1'b0 || dut.out_cnt_q !== 3'd0) begin fails++; $display("FAIL simul_empty: got valid=%b out=%0d want 0/0", wb_valid_o, dut.out_cnt_q); end
  endtask

  task automatic test_overflow();
    cordic_valid_i = 1'b1; cordic_result_i = 32'h0000_0BAD; cordic_trans_id_i = 3'd2;
    step();
    cordic_valid_i = 1'b0;
    settle();
    tests++; if (overflow_o !== 1'b1 || wb_valid_o !== 1'b0 || dut.fifo_occ !== 3'd0) begin fails++; $display("FAIL ovf_set: got ovf=%b valid=%b occ=%0d want 1/0/0", overflow_o, wb_valid_o, dut.fifo_occ); end
    $display("[TB] overflow: orphan result 00000bad rejected");
    repeat (3) step();
    tests++; if (overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow_o); end
    issue_valid_i = 1'b1;
    step();
    issue_valid_i = 1'b0;
    cordic_valid_i = 1'b1; cordic_result_i = 32'h0000_0077; cordic_trans_id_i = 3'd7;
    step();
    cordic_valid_i = 1'b0;
    settle();
    tests++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'h77) begin fails++; $display("FAIL ovf_live_entry: got %b %h want 1 77", wb_valid_o, wb_result_o); end
    // Reset asserted between clock edges must clear state at once.
    rst_i = 1'b1;
    settle();
    tests++; if (wb_valid_o !== 1'b0 || wb_result_o !== 32'h0 || wb_trans_id_o !== 3'd0) begin fails++; $display("FAIL async_rst_wb: got %b %h/%0d want 0 0/0", wb_valid_o, wb_result_o, wb_trans_id_o); end
    tests++; if (overflow_o !== 1'b0 || issue_ready_o !== 1'b0 || dut.out_cnt_q !== 3'd0) begin fails++; $display("FAIL async_rst_state: got ovf=%b ready=%b out=%0d want 0/0/0", overflow_o, issue_ready_o, dut.out_cnt_q); end
    step();
    rst_i = 1'b0;
    settle();
    tests++; if (issue_ready_o !== 1'b1 || overflow_o !== 1'b0) begin fails++; $display("FAIL post_rst: got ready=%b ovf=%b want 1/0", issue_ready_o, overflow_o); end
    $display("[TB] overflow: mid-stream reset cleared all outputs");
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_credit();
    test_flush_outstanding();
    test_flush_coincident();
    test_back_to_back();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
